// File: rtl/param_sync_fifo_pkg.sv
// Shared types and helpers for param_sync_fifo.
// Optional feature macro: SYNC_FIFO_PARITY_EN (per-entry even parity + par_err).
package sync_fifo_pkg;

   // Widest data word the parity helper accepts; narrower words are zero-extended.
   localparam int PAR_MAX_W = 256;

   // Sticky error flags reported by the FIFO.
   typedef struct packed {
      logic ovf;
      logic udf;
      logic par_err;
   } fifo_flags_t;

   // Occupancy counter width: must hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer width: must address 0..depth-1, at least one bit.
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Even parity bit: makes the total number of ones (data + bit) even.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer-facing bundle of param_sync_fifo.
// The par_err signal exists only when SYNC_FIFO_PARITY_EN is defined.
interface param_sync_fifo_if import sync_fifo_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) ();

   localparam int CNT_W = cnt_w(DEPTH);

   logic             clear;
   logic             push;
   logic [WIDTH-1:0] w_data;
   logic             pop;
   logic [WIDTH-1:0] r_data;
   logic             valid;
   logic             ept;
   logic             ful;
   logic             almost_ept;
   logic             almost_ful;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             udf;
`ifdef SYNC_FIFO_PARITY_EN
   logic             par_err;
`endif

   // Agent side: issues requests, observes data and status.
   modport master (
      output clear, push, w_data, pop,
`ifdef SYNC_FIFO_PARITY_EN
      input  par_err,
`endif
      input  r_data, valid, ept, ful, almost_ept, almost_ful, count, ovf, udf
   );

   // FIFO side: accepts requests, drives data and status.
   modport slave (
      input  clear, push, w_data, pop,
`ifdef SYNC_FIFO_PARITY_EN
      output par_err,
`endif
      output r_data, valid, ept, ful, almost_ept, almost_ful, count, ovf, udf
   );

endinterface

// File: rtl/param_sync_fifo_mem.sv
// Storage for param_sync_fifo: DEPTH x DW array, one write port, one
// registered read port. Storage and read register are deliberately not reset
// so the array maps onto block/distributed RAM.
module sync_fifo_mem #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Write port.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read; a same-address write in the same cycle returns the old word.
   always_ff @(posedge clock) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with arbitrary DEPTH (>= 2), occupancy
// count, almost-full/almost-empty thresholds, sticky overflow/underflow and a
// synchronous flush. Read latency is one cycle, no empty bypass.
// Optional feature macro: SYNC_FIFO_PARITY_EN (even parity per entry, par_err).
module param_sync_fifo import sync_fifo_pkg::*; #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clock,
   input  logic             reset,
   param_sync_fifo_if.slave bus
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int PTR_W = ptr_w(DEPTH);
`ifdef SYNC_FIFO_PARITY_EN
   localparam int MEM_W = WIDTH + 1;
`else
   localparam int MEM_W = WIDTH;
`endif

   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_TH);

   logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
   logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_next;
   logic [CNT_W-1:0] r_count, w_count_next;
   logic             r_ept, w_ept_next;
   logic             r_ful, w_ful_next;
   logic             r_almost_ept, w_almost_ept_next;
   logic             r_almost_ful, w_almost_ful_next;
   logic             r_ovf, w_ovf_next;
   logic             r_udf, w_udf_next;
   logic             r_valid;
   logic             r_has_data;
   logic             w_pop_acc;
   logic             w_push_acc;
   logic [MEM_W-1:0] w_wr_word;
   logic [MEM_W-1:0] w_rd_word;

   // Explicit modulo-DEPTH increment; works for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Request acceptance: clear masks both; a full FIFO takes a push only alongside a pop.
   always_comb begin
      w_pop_acc  = !bus.clear && bus.pop && !r_ept;
      w_push_acc = !bus.clear && bus.push && (!r_ful || w_pop_acc);
   end

   // Next pointers, occupancy and sticky error flags.
   always_comb begin
      w_wr_ptr_next = r_wr_ptr;
      w_rd_ptr_next = r_rd_ptr;
      w_count_next  = r_count;
      w_ovf_next    = r_ovf;
      w_udf_next    = r_udf;
      if (bus.clear) begin
         w_wr_ptr_next = '0;
         w_rd_ptr_next = '0;
         w_count_next  = '0;
         w_ovf_next    = 1'b0;
         w_udf_next    = 1'b0;
      end else begin
         if (w_push_acc) begin
            w_wr_ptr_next = ptr_inc(r_wr_ptr);
         end
         if (w_pop_acc) begin
            w_rd_ptr_next = ptr_inc(r_rd_ptr);
         end
         if (w_push_acc && !w_pop_acc) begin
            w_count_next = r_count + CNT_W'(1);
         end else if (!w_push_acc && w_pop_acc) begin
            w_count_next = r_count - CNT_W'(1);
         end
         if (bus.push && r_ful && !bus.pop) begin
            w_ovf_next = 1'b1;
         end
         if (bus.pop && r_ept) begin
            w_udf_next = 1'b1;
         end
      end
   end

   // Status flags derived from the next occupancy so they register in step with count.
   always_comb begin
      w_ept_next        = (w_count_next == '0);
      w_ful_next        = (w_count_next == FULL_CNT);
      w_almost_ept_next = (w_count_next <= AEMPTY_CNT);
      w_almost_ful_next = (w_count_next >= AFULL_CNT);
   end

   // Control state registers; r_has_data masks the unreset read register until the first pop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_ept        <= 1'b1;
         r_ful        <= 1'b0;
         r_almost_ept <= 1'b1;
         r_almost_ful <= 1'b0;
         r_ovf        <= 1'b0;
         r_udf        <= 1'b0;
         r_valid      <= 1'b0;
         r_has_data   <= 1'b0;
      end else begin
         r_wr_ptr     <= w_wr_ptr_next;
         r_rd_ptr     <= w_rd_ptr_next;
         r_count      <= w_count_next;
         r_ept        <= w_ept_next;
         r_ful        <= w_ful_next;
         r_almost_ept <= w_almost_ept_next;
         r_almost_ful <= w_almost_ful_next;
         r_ovf        <= w_ovf_next;
         r_udf        <= w_udf_next;
         r_valid      <= w_pop_acc;
         if (w_pop_acc) begin
            r_has_data <= 1'b1;
         end
      end
   end

   sync_fifo_mem #(
      .DW    (MEM_W),
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_mem (
      .clock   (clock),
      .i_we    (w_push_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_word),
      .i_re    (w_pop_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_word)
   );

`ifdef SYNC_FIFO_PARITY_EN
   logic r_par_err;
   logic w_par_mismatch;

   assign w_wr_word      = {even_parity(PAR_MAX_W'(bus.w_data)), bus.w_data};
   assign w_par_mismatch = r_valid &&
                           (w_rd_word[WIDTH] != even_parity(PAR_MAX_W'(w_rd_word[WIDTH-1:0])));

   // Sticky parity error, cleared by reset or flush.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_par_err <= 1'b0;
      end else if (bus.clear) begin
         r_par_err <= 1'b0;
      end else if (w_par_mismatch) begin
         r_par_err <= 1'b1;
      end
   end

   // A fresh mismatch shows up in the same cycle as the valid word that carries it.
   assign bus.par_err = r_par_err || w_par_mismatch;
`else
   assign w_wr_word = bus.w_data;
`endif

   assign bus.r_data     = r_has_data ? w_rd_word[WIDTH-1:0] : '0;
   assign bus.valid      = r_valid;
   assign bus.ept        = r_ept;
   assign bus.ful        = r_ful;
   assign bus.almost_ept = r_almost_ept;
   assign bus.almost_ful = r_almost_ful;
   assign bus.count      = r_count;
   assign bus.ovf        = r_ovf;
   assign bus.udf        = r_udf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a DEPTH=4 and a DEPTH=5 instance share one
// stimulus stream; a queue-based reference model per instance predicts every
// output after every clock edge. Directed steps first, then random traffic,
// then an asynchronous reset in the middle of a pop.
module tb_param_sync_fifo;
   import sync_fifo_pkg::*;

   localparam int DEP [2] = '{4, 5};
   localparam int AF  [2] = '{3, 3};
   localparam int AE  [2] = '{1, 2};

   logic       clk;
   logic       rst_n;
   logic       t_clr;
   logic       t_push;
   logic       t_pop;
   logic [7:0] t_wd;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  mq [2][$];
   fifo_flags_t m_flags [2];
   logic        m_valid [2];
   logic [7:0]  m_rdata [2];

   param_sync_fifo_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
   param_sync_fifo_if #(.WIDTH(8), .DEPTH(5)) bus5 ();

   assign bus4.clear  = t_clr;
   assign bus4.push   = t_push;
   assign bus4.pop    = t_pop;
   assign bus4.w_data = t_wd;
   assign bus5.clear  = t_clr;
   assign bus5.push   = t_push;
   assign bus5.pop    = t_pop;
   assign bus5.w_data = t_wd;

   param_sync_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) dut4 (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus4)
   );

   param_sync_fifo #(.WIDTH(8), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(2)) dut5 (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int id = 0; id < 2; id++) begin
         mq[id].delete();
         m_flags[id] = '0;
         m_valid[id] = 1'b0;
         m_rdata[id] = 8'h00;
      end
   endtask

   // Reference behaviour for one clock edge, from the FIFO rules alone.
   task automatic model_step();
      for (int id = 0; id < 2; id++) begin
         int   sz;
         logic pa;
         logic wa;
         sz = mq[id].size();
         if (t_clr) begin
            mq[id].delete();
            m_flags[id] = '0;
            m_valid[id] = 1'b0;
         end else begin
            pa = t_pop && (sz > 0);
            wa = t_push && ((sz < DEP[id]) || pa);
            if (t_pop && sz == 0) m_flags[id].udf = 1'b1;
            if (t_push && sz == DEP[id] && !t_pop) m_flags[id].ovf = 1'b1;
            m_valid[id] = pa;
            if (pa) m_rdata[id] = mq[id].pop_front();
            if (wa) mq[id].push_back(t_wd);
         end
      end
   endtask

   task automatic check_all();
      for (int id = 0; id < 2; id++) begin
         logic [7:0] rd;
         logic [2:0] cn;
         logic       v, e, f, ae, af, ov, ud;
         int         sz;
         string      p;
         if (id == 0) begin
            rd = bus4.r_data; cn = bus4.count; v = bus4.valid; e = bus4.ept;
            f = bus4.ful; ae = bus4.almost_ept; af = bus4.almost_ful;
            ov = bus4.ovf; ud = bus4.udf;
         end else begin
            rd = bus5.r_data; cn = bus5.count; v = bus5.valid; e = bus5.ept;
            f = bus5.ful; ae = bus5.almost_ept; af = bus5.almost_ful;
            ov = bus5.ovf; ud = bus5.udf;
         end
         sz = mq[id].size();
         p  = $sformatf("d%0d_", DEP[id]);
         cmp({p, "count"},      32'(cn), 32'(sz));
         cmp({p, "ept"},        32'(e),  32'(sz == 0));
         cmp({p, "ful"},        32'(f),  32'(sz == DEP[id]));
         cmp({p, "almost_ept"}, 32'(ae), 32'(sz <= AE[id]));
         cmp({p, "almost_ful"}, 32'(af), 32'(sz >= AF[id]));
         cmp({p, "ovf"},        32'(ov), 32'(m_flags[id].ovf));
         cmp({p, "udf"},        32'(ud), 32'(m_flags[id].udf));
         cmp({p, "valid"},      32'(v),  32'(m_valid[id]));
         cmp({p, "r_data"},     32'(rd), 32'(m_rdata[id]));
      end
`ifdef SYNC_FIFO_PARITY_EN
      cmp("d4_par_err", 32'(bus4.par_err), 32'd0);
      cmp("d5_par_err", 32'(bus5.par_err), 32'd0);
`endif
   endtask

   // One clock: drive inputs, advance the model on the edge, compare just after it.
   task automatic cycle(input logic c, input logic pu, input logic po, input logic [7:0] d);
      t_clr  = c;
      t_push = pu;
      t_pop  = po;
      t_wd   = d;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      logic [7:0] fill [4];
      fill = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst_n  = 1'b0;
      t_clr  = 1'b0;
      t_push = 1'b0;
      t_pop  = 1'b0;
      t_wd   = 8'h00;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // Fill the DEPTH=4 instance; almost_ful at 3, ful at 4.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, fill[i]);
         cmp("fill_count", 32'(bus4.count), 32'(i + 1));
      end
      cmp("fill_ful", 32'(bus4.ful), 32'd1);

      // Push into a full FIFO without pop: overflow, nothing stored.
      cycle(1'b0, 1'b1, 1'b0, 8'h55);
      cmp("ovf_set", 32'(bus4.ovf), 32'd1);

      // Full with simultaneous push/pop: read-before-write, count stays 4.
      cycle(1'b0, 1'b1, 1'b1, 8'hAA);
      cmp("swap_rdata", 32'(bus4.r_data), 32'h11);
      cmp("swap_count", 32'(bus4.count), 32'd4);

      // Drain; the last word must be the swapped-in 0xAA, never 0x55.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
      cmp("drain_last", 32'(bus4.r_data), 32'hAA);
      cmp("drain_ept", 32'(bus4.ept), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Empty with simultaneous push/pop: no bypass, underflow, word stored.
      cycle(1'b0, 1'b1, 1'b1, 8'h77);
      cmp("empty_udf", 32'(bus4.udf), 32'd1);
      cmp("empty_valid", 32'(bus4.valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      cmp("empty_pop_data", 32'(bus4.r_data), 32'h77);

      // Flush with three entries and a push in the same cycle.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
      cycle(1'b1, 1'b1, 1'b0, 8'h99);
      cmp("clear_count", 32'(bus4.count), 32'd0);
      cmp("clear_udf", 32'(bus4.udf), 32'd0);
      cmp("clear_rdata_held", 32'(bus4.r_data), 32'h77);

      // Pointer wrap: steady push/pop pairs around a small backlog.
      cycle(1'b0, 1'b1, 1'b0, 8'hA0);
      cycle(1'b0, 1'b1, 1'b0, 8'hA1);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 8'(8'hB0 + i));

      // Random traffic in fill-heavy, drain-heavy and balanced phases.
      for (int i = 0; i < 600; i++) begin
         int   mode;
         int   pp;
         logic pu, po, c;
         mode = (i / 40) % 3;
         pp   = (mode == 0) ? 80 : ((mode == 1) ? 20 : 50);
         pu   = ($urandom_range(99) < pp);
         po   = ($urandom_range(99) < (100 - pp));
         c    = ($urandom_range(59) == 0);
         cycle(c, pu, po, 8'($urandom));
      end

      // Asynchronous reset while a popped word is valid.
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h5A);
      cycle(1'b0, 1'b1, 1'b0, 8'hA5);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      cmp("pre_rst_valid", 32'(bus4.valid), 32'd1);
      t_pop = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      t_pop = 1'b0;
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      cycle(1'b0, 1'b1, 1'b0, 8'h3C);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      cmp("post_rst_data", 32'(bus4.r_data), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO; next generation of the team's sync FIFO. Adds generic WIDTH/DEPTH (any DEPTH ≥ 2, not only powers of two), programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags and a synchronous flush. Sits between producer and consumer agents on the same clock; `clock`/`reset`/`push`/`pop`/`w_data`/`r_data`/`valid`/`ept`/`ful` keep the existing bench semantics.

Parameters:
WIDTH, 8, data bits per entry
DEPTH, 16, number of entries (≥ 2, any integer)
AFULL_TH, DEPTH-2, almost_ful asserted when count ≥ AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_ept asserted when count ≤ AEMPTY_TH (0..DEPTH-1)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
clear  in  1  synchronous flush
push  in  1  write request
w_data  in  WIDTH  write data
pop  in  1  read request
r_data  out  WIDTH  registered read data
valid  out  1  r_data carries a newly popped word this cycle
ept  out  1  FIFO empty
ful  out  1  FIFO full
almost_ept  out  1  count ≤ AEMPTY_TH
almost_ful  out  1  count ≥ AFULL_TH
count  out  CNT_W  occupancy, CNT_W = $clog2(DEPTH+1)
ovf  out  1  sticky overflow
udf  out  1  sticky underflow

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=count=0; r_data=0, valid=0, ept=1, ful=0, almost_ept=1, almost_ful=0, ovf=0, udf=0. Storage array is not reset.
- Pop accepted: pop && !ept. Push accepted: push && (!ful || pop accepted). At full, a simultaneous push+pop succeeds (read before write), and count stays DEPTH.
- Empty: pop is rejected and there is no bypass, even with a simultaneous push. The push is stored and the count goes to 1.
- Read latency 1: an accepted pop in cycle N gives r_data = head word and valid=1 in cycle N+1. Without an accepted pop, valid=0 and r_data holds its last value.
- Write: an accepted push stores w_data at wr_ptr; the word is poppable from the next cycle.
- Pointers increment modulo DEPTH (explicit wrap DEPTH-1 → 0); no power-of-two arithmetic.
- count_next = count + push_acc - pop_acc. ept, ful, almost_ept and almost_ful are registered, computed from count_next, and consistent with count every cycle. ept and ful are never 1 together.
- ovf sets on push && ful && !pop. udf sets on pop && ept. Both are sticky until reset or clear. The rejected operation has no other effect.
- clear=1: next cycle pointers/count=0, ept=1, ful=0, almost flags follow count=0, valid=0, ovf=udf=0. push/pop in the clear cycle are ignored and do not set the flags. r_data is held.
- Reset mid-operation: immediate return to reset state. An in-flight valid is dropped.

Optional Feature:
SYNC_FIFO_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit computed from w_data at write.
  - On read, parity is rechecked. Mismatch sets output par_err (1 bit, sticky, cleared by reset/clear), aligned with valid.
  - Port par_err exists only when defined.
- Undefined: no parity storage, no par_err port; behaviour otherwise identical.

Decomposition:
- Package sync_fifo_pkg:
  - function cnt_w(depth) returning $clog2(depth+1)
  - function ptr_w(depth)
  - function even_parity(data) for the parity option
  - typedef of the flag bundle {ovf, udf, par_err}
- One sub-module, sync_fifo_mem: DEPTH×(WIDTH[+1]) array with one write port and one registered read port. No reset on storage.
- Control, pointers, count and flags live in param_sync_fifo.

Test Plan (WIDTH=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1 unless noted):
- Reset then push 0x11,0x22,0x33,0x44 → count 1..4; almost_ful at count 3; ful=1 after 4th push; ovf=0; pop ×4 → r_data 0x11,0x22,0x33,0x44, each with valid one cycle after pop; ept=1 at end.
- Full + push 0x55 without pop → ovf=1 sticky; count=4; next pops return 0x11..0x44, never 0x55.
- Full + simultaneous push 0xAA/pop → r_data=0x11 valid next cycle; count stays 4; last pop returns 0xAA.
- Empty + simultaneous push 0x77/pop → udf=1, valid=0, count=1; next pop → r_data=0x77.
- DEPTH=5: 12 push/pop pairs → pointer wrap; data order preserved; count never exceeds 5.
- clear with count=3 and push asserted → count=0, ept=1, ovf/udf cleared. Async reset mid-pop → valid=0 and all outputs at reset values immediately.
